btn_conditioner: RTL and testbench

Conditions the five raw Basys3 push-buttons into clean per-button level, press, release and hold signals for the display-task blocks. It synchronises each button, debounces it, and applies a repeat lockout, which replaces ad-hoc delay counters inside the task logic. It sits directly upstream of the task/pixel-generation stage and runs in the 6.25 MHz display clock domain.

---
 rtl/btn_pkg.sv | 22 ++
 rtl/btn_channel.sv | 132 +++++++++++++
 rtl/btn_conditioner.sv | 35 +++
 tb/tb_btn_conditioner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning path.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    // Defaults sized for the 6.25 MHz display clock: 20 ms, 200 ms, 1 s.
    localparam int DEF_DEBOUNCE_CYC = 125000;
    localparam int DEF_LOCKOUT_CYC  = 1250000;
    localparam int DEF_HOLD_CYC     = 6250000;

    localparam int BTN_C = 0;
    localparam int BTN_U = 1;
    localparam int BTN_L = 2;
    localparam int BTN_R = 3;
    localparam int BTN_D = 4;

endpackage

// File: rtl/btn_channel.sv
// One button lane: two-flop synchroniser, debounce FSM, press lockout and hold timer.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LOCKOUT_CYC  = DEF_LOCKOUT_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic clk_6p25m,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_hold
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYC + 1);
    localparam int LOCK_W = $clog2(LOCKOUT_CYC + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCKOUT_CYC);
    localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [1:0]        sync_q;
    logic              s;
    btn_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              press_q, press_d;
    logic              release_q, release_d;
    logic              accept_press;

    assign s = sync_q[1];

    always_ff @(posedge clk_6p25m or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b00;
            state_q   <= IDLE;
            cnt_q     <= '0;
            lock_q    <= '0;
            hold_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lock_q    <= lock_d;
            hold_q    <= hold_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        accept_press = 1'b0;
        release_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d      = PRESSED;
                    cnt_d        = '0;
                    accept_press = 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // An accepted press only pulses once the previous lockout has fully drained.
        press_d = accept_press && (lock_q == '0);

        lock_d = lock_q;
        if (press_d) begin
            lock_d = LOCK_MAX;
        end else if (lock_q != '0) begin
            lock_d = lock_q - LOCK_ONE;
        end

        hold_d = hold_q;
        if (state_d == IDLE || press_d) begin
            hold_d = '0;
        end else if ((state_q == PRESSED || state_q == RELEASE_WAIT) && hold_q != HOLD_MAX) begin
            hold_d = hold_q + HOLD_ONE;
        end
    end

    assign btn_level   = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign btn_hold    = (hold_q == HOLD_MAX);

endmodule

// File: rtl/btn_conditioner.sv
// Conditions the Basys3 push-buttons {D,R,L,U,C} into level/press/release/hold strobes.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN        = 5,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int LOCKOUT_CYC  = DEF_LOCKOUT_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC
) (
    input  logic             clk_6p25m,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_hold
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .LOCKOUT_CYC (LOCKOUT_CYC),
            .HOLD_CYC    (HOLD_CYC)
        ) u_chan (
            .clk_6p25m  (clk_6p25m),
            .rst_n      (rst_n),
            .btn_raw    (btn_raw[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_hold   (btn_hold[i])
        );
    end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed plus randomised bench for btn_conditioner, checked against a run-length reference model.
module tb_btn_conditioner;

    localparam int N    = 5;
    localparam int DEB  = 4;
    localparam int LOCK = 10;
    localparam int HOLD = 20;

    logic         clk_6p25m = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_hold;

    int checks   = 0;
    int failures = 0;

    always #5 clk_6p25m = ~clk_6p25m;

    btn_conditioner #(
        .N_BTN       (N),
        .DEBOUNCE_CYC(DEB),
        .LOCKOUT_CYC (LOCK),
        .HOLD_CYC    (HOLD)
    ) dut (
        .clk_6p25m  (clk_6p25m),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold)
    );

    // Reference: a change is accepted once the synchronised input has disagreed with
    // the level for DEB+1 consecutive samples; lockout and hold are edge-time differences.
    logic [N-1:0] m_sync1, m_sync2, m_level, m_press, m_release, m_hold;
    int           m_run[N];
    int           m_last_press[N];
    int           m_rise[N];
    int           cyc;

    function automatic void model_reset();
        m_sync1   = '0;
        m_sync2   = '0;
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_hold    = '0;
        for (int b = 0; b < N; b++) begin
            m_run[b]        = 0;
            m_last_press[b] = -1000;
            m_rise[b]       = 0;
        end
    endfunction

    function automatic void model_step();
        logic s;
        cyc++;
        m_press   = '0;
        m_release = '0;
        for (int b = 0; b < N; b++) begin
            s          = m_sync2[b];
            m_sync2[b] = m_sync1[b];
            m_sync1[b] = btn_raw[b];
            if (s != m_level[b]) m_run[b]++;
            else m_run[b] = 0;
            if (m_run[b] == DEB + 1) begin
                m_run[b]   = 0;
                m_level[b] = s;
                if (s) begin
                    m_rise[b] = cyc;
                    if (cyc - m_last_press[b] > LOCK) begin
                        m_press[b]      = 1'b1;
                        m_last_press[b] = cyc;
                    end
                end else begin
                    m_release[b] = 1'b1;
                end
            end
            m_hold[b] = m_level[b] && (cyc - m_rise[b] >= HOLD);
        end
    endfunction

    task automatic check_vec(input string tag, input logic [N-1:0] obs, input logic [N-1:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b cycle=%0d", tag, obs, want, cyc);
        end
    endtask

    task automatic check_output();
        check_vec("level", btn_level, m_level);
        check_vec("press", btn_press, m_press);
        check_vec("release", btn_release, m_release);
        check_vec("hold", btn_hold, m_hold);
    endtask

    task automatic tick();
        @(posedge clk_6p25m);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk_6p25m);
        check_output();
    endtask

    task automatic apply_stimulus(input logic [N-1:0] raw, input int n);
        btn_raw = raw;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_vec("reset_level", btn_level, '0);
        check_vec("reset_press", btn_press, '0);
        check_vec("reset_release", btn_release, '0);
        check_vec("reset_hold", btn_hold, '0);
    endtask

    initial begin
        logic [N-1:0] raw;
        cyc     = 0;
        btn_raw = 5'b11111;
        model_reset();
        $display("[TB] start");

        // All buttons held through reset: fresh simultaneous press on the 7th edge after release.
        assert_reset();
        apply_stimulus(5'b11111, 3);
        rst_n = 1'b1;
        apply_stimulus(5'b11111, 6);
        check_vec("first_press_early", btn_press, 5'b00000);
        apply_stimulus(5'b11111, 1);
        check_vec("first_press", btn_press, 5'b11111);
        apply_stimulus(5'b11111, 1);
        check_vec("first_press_width", btn_press, 5'b00000);
        apply_stimulus(5'b00000, 20);

        // Short glitch on C is swallowed; a long press is accepted and later released.
        apply_stimulus(5'b00001, 3);
        apply_stimulus(5'b00000, 5);
        check_vec("glitch_level", btn_level & 5'b00001, 5'b00000);
        apply_stimulus(5'b00001, 6);
        check_vec("c_press_early", btn_press, 5'b00000);
        apply_stimulus(5'b00001, 1);
        check_vec("c_press", btn_press, 5'b00001);
        apply_stimulus(5'b00001, 3);
        apply_stimulus(5'b00000, 6);
        check_vec("c_level_held", btn_level, 5'b00001);
        apply_stimulus(5'b00000, 1);
        check_vec("c_release", btn_release, 5'b00001);
        check_vec("c_level_low", btn_level, 5'b00000);
        apply_stimulus(5'b00000, 5);

        // D re-pressed inside the lockout window rises silently; a later press pulses again.
        apply_stimulus(5'b10000, 5);
        apply_stimulus(5'b00000, 5);
        apply_stimulus(5'b10000, 7);
        check_vec("d_locked_level", btn_level, 5'b10000);
        check_vec("d_locked_press", btn_press, 5'b00000);
        apply_stimulus(5'b00000, 7);
        apply_stimulus(5'b10000, 7);
        check_vec("d_third_press", btn_press, 5'b10000);
        apply_stimulus(5'b00000, 10);

        // L held long enough to assert hold, then released.
        apply_stimulus(5'b00100, 7);
        check_vec("l_level", btn_level, 5'b00100);
        apply_stimulus(5'b00100, 19);
        check_vec("l_hold_early", btn_hold, 5'b00000);
        apply_stimulus(5'b00100, 1);
        check_vec("l_hold", btn_hold, 5'b00100);
        apply_stimulus(5'b00100, 10);
        apply_stimulus(5'b00000, 6);
        check_vec("l_hold_kept", btn_hold, 5'b00100);
        apply_stimulus(5'b00000, 1);
        check_vec("l_hold_fall", btn_hold, 5'b00000);
        check_vec("l_release", btn_release, 5'b00100);
        apply_stimulus(5'b00000, 5);

        // C steady while R chatters at period 2; only C pulses until R settles.
        for (int i = 0; i < 10; i++) begin
            apply_stimulus((i % 2 == 0) ? 5'b01001 : 5'b00001, 1);
            if (i == 6) check_vec("chatter_c_press", btn_press, 5'b00001);
        end
        check_vec("chatter_r_level", btn_level & 5'b01000, 5'b00000);
        apply_stimulus(5'b01001, 7);
        check_vec("r_settled_press", btn_press, 5'b01000);
        apply_stimulus(5'b00000, 10);

        // Reset while U is mid-hold: outputs clear with no release, then a fresh press.
        apply_stimulus(5'b00010, 7);
        apply_stimulus(5'b00010, 15);
        assert_reset();
        apply_stimulus(5'b00010, 3);
        check_vec("u_no_release", btn_release, 5'b00000);
        rst_n = 1'b1;
        apply_stimulus(5'b00010, 6);
        check_vec("u_repress_early", btn_press, 5'b00000);
        apply_stimulus(5'b00010, 1);
        check_vec("u_repress", btn_press, 5'b00010);
        apply_stimulus(5'b00000, 10);

        // Random per-button toggling with one reset in the middle.
        raw = '0;
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 6) == 0) raw[b] = ~raw[b];
            end
            if (c == 700) begin
                assert_reset();
                apply_stimulus(raw, 2);
                rst_n = 1'b1;
            end
            apply_stimulus(raw, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
